// File: rtl/sound_buffering_if.sv
// Audio buffer bus: packet byte stream in, stereo samples out, plus status.
// master = packet source / DAC side, slave = the sound buffer.
interface sound_buffering_if #(
  parameter int ADDR_W = 10
);
  logic            new_sample;
  logic            sound_packet;
  logic            rx_valid;
  logic [7:0]      rx_data;
  logic [15:0]     left_channel;
  logic [15:0]     right_channel;
  logic [7:0]      seq;    // last packet sequence number seen
  logic [ADDR_W:0] fill;   // buffered stereo samples

  modport master (
    output new_sample, sound_packet, rx_valid, rx_data,
    input  left_channel, right_channel, seq, fill
  );

  modport slave (
    input  new_sample, sound_packet, rx_valid, rx_data,
    output left_channel, right_channel, seq, fill
  );
endinterface

// File: rtl/sound_buffering.sv
// sound_buffering: parses sound packets into a stereo-sample ring buffer and
// releases one sample per new_sample rising edge once the prefill is reached.
// Optional build macro SOUND_MUTE_ON_UNDERRUN_EN: output silence on underrun
// and on strobes while waiting for prefill (otherwise outputs hold).
module sound_buffering #(
  parameter int ADDR_W             = 10,
  parameter int SAMPLES_PER_PACKET = 240,
  parameter int PREFILL            = 480
) (
  input logic              clk,
  input logic              reset,
  sound_buffering_if.slave bus
);
  localparam int              DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL      = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] PREFILL_N = (ADDR_W+1)'(PREFILL);
  localparam logic [9:0]      LAST_BYTE = 10'(4*SAMPLES_PER_PACKET - 1);

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PAYLOAD} state_t;

  state_t            r_state, w_state_nxt;
  logic [9:0]        r_byte_cnt;
  logic [7:0]        r_seq;
  logic [23:0]       r_part;      // L_lo, L_hi, R_lo of the sample in flight
  logic [31:0]       r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR_W:0]   r_fill;
  logic              r_play, r_ns_d, r_rd_vld;
  logic [31:0]       r_rd_data;
  logic [15:0]       r_left, r_right;

  logic w_byte_hdr, w_byte_pay, w_smp_done, w_wr_en;
  logic w_event, w_rd_en, w_underrun;

  // A packet start always wins over a byte arriving in the same cycle.
  assign w_byte_hdr = (r_state == S_HEADER)  && bus.rx_valid && !bus.sound_packet;
  assign w_byte_pay = (r_state == S_PAYLOAD) && bus.rx_valid && !bus.sound_packet;
  assign w_smp_done = w_byte_pay && (r_byte_cnt[1:0] == 2'd3);
  // Full is judged before this cycle's read, so a full buffer drops the sample.
  assign w_wr_en    = w_smp_done && (r_fill != FULL);

  assign w_event    = bus.new_sample & ~r_ns_d;
  // Empty is judged before this cycle's write, so a fresh sample is never read.
  assign w_rd_en    = w_event & r_play & (r_fill != '0);
  assign w_underrun = w_event & r_play & (r_fill == '0);

  // Parser state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Parser next state: packet start restarts from HEADER in any state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (bus.sound_packet) w_state_nxt = S_HEADER;
      S_HEADER:  if (bus.sound_packet) w_state_nxt = S_HEADER;
                 else if (w_byte_hdr)  w_state_nxt = S_PAYLOAD;
      S_PAYLOAD: if (bus.sound_packet) w_state_nxt = S_HEADER;
                 else if (w_byte_pay && r_byte_cnt == LAST_BYTE) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Parser datapath: sequence capture, byte count and partial sample bytes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seq      <= '0;
      r_byte_cnt <= '0;
      r_part     <= '0;
    end else if (bus.sound_packet) begin
      r_byte_cnt <= '0;
    end else if (w_byte_hdr) begin
      r_seq      <= bus.rx_data;
      r_byte_cnt <= '0;
    end else if (w_byte_pay) begin
      r_byte_cnt <= r_byte_cnt + 10'd1;
      case (r_byte_cnt[1:0])
        2'd0:    r_part[7:0]   <= bus.rx_data;
        2'd1:    r_part[15:8]  <= bus.rx_data;
        2'd2:    r_part[23:16] <= bus.rx_data;
        default: ;
      endcase
    end
  end

  // Sample RAM: word is {L_hi, L_lo, R_hi, R_lo}; synchronous read port.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= {r_part[15:0], bus.rx_data, r_part[23:16]};
    if (w_rd_en) r_rd_data <= r_mem[r_rd_ptr];
  end

  // Ring pointers and fill; simultaneous write and read leaves fill unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_en, w_rd_en})
        2'b10:   r_fill <= r_fill + (ADDR_W+1)'(1);
        2'b01:   r_fill <= r_fill - (ADDR_W+1)'(1);
        default: ;
      endcase
    end
  end

  // Playback control: strobe edge detect and prefill/underrun enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ns_d   <= 1'b0;
      r_play   <= 1'b0;
      r_rd_vld <= 1'b0;
    end else begin
      r_ns_d   <= bus.new_sample;
      r_rd_vld <= w_rd_en;
      if (w_underrun)               r_play <= 1'b0;
      else if (r_fill >= PREFILL_N) r_play <= 1'b1;
    end
  end

`ifdef SOUND_MUTE_ON_UNDERRUN_EN
  logic r_mute;

  // Remember a strobe that found nothing to play so the outputs go silent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_mute <= 1'b0;
    else       r_mute <= w_underrun | (w_event & ~r_play);
  end

  // Output registers: sample lands one edge after the RAM read, or silence.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_left  <= '0;
      r_right <= '0;
    end else if (r_rd_vld) begin
      r_left  <= r_rd_data[31:16];
      r_right <= r_rd_data[15:0];
    end else if (r_mute) begin
      r_left  <= '0;
      r_right <= '0;
    end
  end
`else
  // Output registers: sample lands one edge after the RAM read, else hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_left  <= '0;
      r_right <= '0;
    end else if (r_rd_vld) begin
      r_left  <= r_rd_data[31:16];
      r_right <= r_rd_data[15:0];
    end
  end
`endif

  assign bus.left_channel  = r_left;
  assign bus.right_channel = r_right;
  assign bus.seq           = r_seq;
  assign bus.fill          = r_fill;
endmodule

// File: tb/tb_sound_buffering.sv
// Directed bench for sound_buffering with a queue model of the ring buffer.
module tb_sound_buffering;
  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  logic [31:0] q[$];          // expected buffer contents {L,R}
  bit          play = 1'b0;   // expected playback enable
  logic [31:0] out  = '0;     // expected {left,right}

  sound_buffering_if bus ();
  sound_buffering dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] bv(input int k);
    return k[7:0];
  endfunction

  task automatic check_fill(input string tag);
    check32(tag, 32'(bus.fill), q.size());
  endtask

  task automatic check_out(input string tag, input logic [31:0] exp);
    check32(tag, {bus.left_channel, bus.right_channel}, exp);
  endtask

  // Pulse sound_packet, send header then payload bytes 1..nbytes (mod 256).
  task automatic send_packet(input logic [7:0] sq, input int nbytes, input int gap_every);
    @(negedge clk) bus.sound_packet = 1'b1;
    @(negedge clk) bus.sound_packet = 1'b0;
    bus.rx_valid = 1'b1; bus.rx_data = sq;
    @(negedge clk);
    for (int k = 1; k <= nbytes; k++) begin
      bus.rx_valid = 1'b1; bus.rx_data = bv(k);
      @(negedge clk);
      if (k % 4 == 0 && q.size() < 1024) begin
        q.push_back({bv(k-2), bv(k-3), bv(k), bv(k-1)});
        if (q.size() >= 480) play = 1'b1;
      end
      if (gap_every != 0 && k % gap_every == 0) begin
        bus.rx_valid = 1'b0;
        @(negedge clk);
      end
    end
    bus.rx_valid = 1'b0;
    @(negedge clk);
  endtask

  // One 20-clock strobe period; new_sample held high for 'hold' cycles.
  task automatic strobe(input int hold, input string tag);
    @(negedge clk) bus.new_sample = 1'b1;
    repeat (hold) @(negedge clk);
    bus.new_sample = 1'b0;
    repeat (19 - hold) @(negedge clk);
    if (play && q.size() > 0) out = q.pop_front();
    else begin
      if (play) play = 1'b0;
`ifdef SOUND_MUTE_ON_UNDERRUN_EN
      out = '0;
`endif
    end
    check_out(tag, out);
  endtask

  initial begin
    bus.new_sample = 1'b0; bus.sound_packet = 1'b0;
    bus.rx_valid = 1'b0;   bus.rx_data = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_out("reset_out", 32'h0);
    check_fill("reset_fill");
    check32("reset_seq", 32'(bus.seq), 32'h0);
    reset = 1'b0;

    // First packet with gaps: below prefill, no playback.
    send_packet(8'd0, 960, 7);
    check_fill("pktA_fill");
    check32("pktA_fill_const", 32'(bus.fill), 240);
    check32("pktA_seq", 32'(bus.seq), 32'd0);
    for (int k = 0; k < 5; k++) begin
      bus.rx_valid = 1'b1; bus.rx_data = 8'hAA;
      @(negedge clk);
    end
    bus.rx_valid = 1'b0;
    check_fill("idle_bytes_ignored");
    strobe(1, "prefill_wait0");
    strobe(3, "prefill_wait1");
    check_out("prefill_out_zero", 32'h0);

    // Second packet reaches prefill; check documented samples.
    send_packet(8'd1, 960, 0);
    check32("pktB_fill", 32'(bus.fill), 480);
    check32("pktB_seq", 32'(bus.seq), 32'd1);
    strobe(1, "s1");
    check_out("s1_const", 32'h0201_0403);
    strobe(5, "s2_held");
    check_out("s2_const", 32'h0605_0807);
    for (int i = 3; i <= 65; i++) begin
      strobe(1, "s_loop");
      if (i == 64) check_out("s64_const", 32'hFEFD_00FF);
      if (i == 65) check_out("s65_const", 32'h0201_0403);
    end
    check32("fill_415", 32'(bus.fill), 415);

    // Fill to capacity; excess samples dropped.
    send_packet(8'd2, 960, 0);
    send_packet(8'd3, 960, 0);
    send_packet(8'd4, 960, 0);
    check32("full_fill", 32'(bus.fill), 1024);
    check_fill("full_model");

    // Drain across the pointer wrap, then underrun.
    for (int i = 0; i < 1024; i++) strobe(1, "drain");
    check32("drained_fill", 32'(bus.fill), 0);
    strobe(1, "underrun");
    check_fill("underrun_fill");

    // Playback needs a full prefill again.
    send_packet(8'd6, 960, 0);
    strobe(1, "reprefill_wait");
    send_packet(8'd7, 960, 0);
    strobe(1, "restart_play");
    check_out("restart_const", 32'h0201_0403);

    // Packet restart after 6 payload bytes keeps only the first sample.
    send_packet(8'd8, 6, 0);
    send_packet(8'd9, 960, 0);
    check32("restart_fill", 32'(bus.fill), 720);
    check32("restart_seq", 32'(bus.seq), 32'd9);

    // Reads and writes overlapping in time.
    fork
      send_packet(8'd10, 960, 0);
      for (int i = 0; i < 20; i++) strobe(1, "concurrent");
    join
    check32("concurrent_fill", 32'(bus.fill), 940);

    // Reset mid-packet, then a clean packet parses from its header.
    send_packet(8'd11, 6, 0);
    reset = 1'b1;
    q.delete(); play = 1'b0; out = '0;
    @(negedge clk);
    check_out("midreset_out", 32'h0);
    check32("midreset_fill", 32'(bus.fill), 0);
    reset = 1'b0;
    send_packet(8'd12, 960, 0);
    check32("post_reset_fill", 32'(bus.fill), 240);
    check32("post_reset_seq", 32'(bus.seq), 32'd12);
    strobe(1, "post_reset_wait");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sound_buffering.md
Name: sound_buffering

Overview:
- Receives audio packets from the network byte stream and stores them as stereo 16-bit samples in an on-chip FIFO ring buffer.
- Releases one stereo sample per sample-rate strobe to the audio DAC path.
- Sits between the packet receiver/classifier (which raises sound_packet) and the codec/I2S transmitter.

Parameters:
- ADDR_W, 10, log2 of buffer depth in stereo samples (1024 samples).
- SAMPLES_PER_PACKET, 240, stereo samples per packet payload (payload = 4*240 = 960 bytes).
- PREFILL, 480, buffered samples required before playback starts or restarts.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- new_sample  in  1  sample-rate strobe; its rising edge requests the next sample.
- left_channel  out  16  current left sample (two's complement).
- right_channel  out  16  current right sample (two's complement).
- sound_packet  in  1  one-cycle pulse marking the start of a sound packet; the bytes follow on rx_valid/rx_data.
- rx_valid  in  1  rx_data is valid this cycle.
- rx_data  in  8  received byte.

Behaviour:
- Reset (async, active-high):
  - left_channel/right_channel = 0.
  - Write/read pointers and fill count = 0.
  - Parser in IDLE; playback disabled; seq register = 0.
- Parser FSM: IDLE, HEADER, PAYLOAD.
  - IDLE -> HEADER on sound_packet=1.
  - HEADER: first rx_valid byte is the packet sequence number (0..199). Store it in an internal seq register, then go to PAYLOAD.
  - PAYLOAD: each rx_valid byte increments a 10-bit byte counter. Byte order per sample is L_lo, L_hi, R_lo, R_hi.
  - On the 4th byte of a sample, write {L,R} (32 bits) to mem[wr_ptr], advance wr_ptr (wraps modulo 2^ADDR_W) and increment fill.
  - After 4*SAMPLES_PER_PACKET bytes -> IDLE. Further rx_valid bytes in IDLE are ignored.
  - rx_valid low cycles are gaps; no state change.
  - sound_packet in HEADER or PAYLOAD restarts at HEADER. Any partial sample is discarded; samples already written stay in the buffer.
- Full: if fill == 2^ADDR_W when a sample completes, drop that sample (no pointer or fill change). The parser keeps counting bytes.
- Playback:
  - Edge detect: ns_d is new_sample registered. Event = new_sample & ~ns_d, evaluated at clock edge N.
  - Playback enable sets when fill >= PREFILL.
  - On an event with playback enabled and fill > 0: read mem[rd_ptr] and advance rd_ptr (wraps). Outputs take the read value at edge N+1; exactly one sample per event.
  - On an event with fill == 0 (underrun): clear playback enable and hold the outputs. Playback resumes only after fill >= PREFILL again.
  - Before playback is enabled, events are ignored and outputs hold.
- Simultaneous write and read in the same cycle: fill stays unchanged (+1 and -1 both applied).
- A read never returns a sample written in the same cycle. Empty is judged on the fill value before the write.
- A new_sample held high for multiple cycles counts as one event.

Optional Feature:
- Macro SOUND_MUTE_ON_UNDERRUN_EN.
- Defined: on an underrun event, and on any event while playback is waiting for prefill, left_channel and right_channel become 0x0000 at edge N+1.
- Not defined: outputs hold their last value in those cases.

Test Plan:
- Reset mid-packet -> outputs 0, fill 0. The next packet parses from HEADER normally.
- One packet: sound_packet pulse, header 0x00, payload bytes 1..960 (8-bit truncated). Result: fill = 240, no playback (below PREFILL), outputs stay 0.
- Second packet with the same payload, then new_sample strobes every 20 clocks:
  - 1st sample: L=0x0201, R=0x0403.
  - 2nd sample: L=0x0605, R=0x0807.
  - 64th sample: L=0xFEFD, R=0x00FF.
  - 65th sample: L=0x0201, R=0x0403 (bytes 257..260 truncate to 1..4).
- Keep sending packets until fill reaches 1024. Next completed sample is dropped; wr_ptr wraps from 1023 to 0 correctly once reads resume.
- Stop packets and strobe until empty. Next event gives an underrun: outputs hold the last sample (macro off) or go to 0 (macro on). Playback restarts only after 480 new samples.
- Re-issue sound_packet after 6 payload bytes -> sample 1 (bytes 1..4) kept, bytes 5..6 discarded. New packet parsing starts with its header byte.
